// File: rtl/loctag_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loctag_pkg
//  Description : Shared types and constants for the LocTag trigger scheduler:
//                scheduler state encoding and the 2-bit operating modes.
//  Revision    : 1.0  initial multi-channel release
// ============================================================================
package loctag_pkg;

    // Scheduler states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        ACTIVE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Operating modes
    localparam logic [1:0] MODE_OFF  = 2'b00;  // no scheduling
    localparam logic [1:0] MODE_GATE = 2'b01;  // steady window
    localparam logic [1:0] MODE_MOD  = 2'b10;  // toggling window
    localparam logic [1:0] MODE_PASS = 2'b11;  // direct trigger reflection

endpackage : loctag_pkg
`default_nettype wire

// File: rtl/loctag_trig_filter.sv
`default_nettype none
// ============================================================================
//  Module      : loctag_trig_filter
//  Description : One trigger channel: 2-FF synchroniser followed by a
//                run-length filter. The output level flips only after
//                FILT_LEN consecutive synchronised samples of the opposite
//                level.
//  Ports       : clk       - system clock
//                reset     - asynchronous active-low reset
//                trig_raw  - raw asynchronous trigger input
//                level     - filtered trigger level
//  Revision    : 1.0  initial multi-channel release
// ============================================================================
module loctag_trig_filter
    import loctag_pkg::*;
#(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic trig_raw,
    output logic level
);

    localparam logic [3:0] RUN_LAST = 4'(FILT_LEN - 1);

    logic       sync_1;
    logic       sync_2;
    logic [3:0] run_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            level   <= 1'b0;
            run_cnt <= '0;
        end else begin
            sync_1 <= trig_raw;
            sync_2 <= sync_1;
            // run_cnt counts opposite-level samples already seen; the
            // FILT_LEN-th one flips the level.
            if (sync_2 == level) begin
                run_cnt <= '0;
            end else if (run_cnt == RUN_LAST) begin
                level   <= sync_2;
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + 4'd1;
            end
        end
    end

endmodule : loctag_trig_filter
`default_nettype wire

// File: rtl/loctag_trig_sched.sv
`default_nettype none
// ============================================================================
//  Module      : loctag_trig_sched
//  Description : Multi-channel trigger conditioner and reflector-control
//                scheduler. Filters NUM_CH raw triggers, arbitrates their
//                rising edges (lowest index wins) and drives the reflector
//                switch for a delayed, mode-shaped window.
//  Ports       : clk           - 50 MHz system clock
//                reset         - asynchronous active-low reset
//                trig_in       - raw triggers, asynchronous
//                ch_en         - per-channel request enable
//                mode          - 00 off, 01 gate, 10 modulate, 11 pass
//                smoothed_trig - filtered trigger levels
//                ctrl_out      - reflector switch drive
//                fire          - one-cycle strobe at window start
//                fire_ch       - channel being served
//                busy          - scheduler not idle
//                missed_cnt    - saturating count of dropped requests
//  Revision    : 1.0  initial multi-channel release
// ============================================================================
module loctag_trig_sched
    import loctag_pkg::*;
#(
    parameter int NUM_CH                 = 4,
    parameter int CLK_MHZ                = 50,
    parameter int FILT_LEN               = 4,
    parameter int TRIG_DELAY_IN_US       = 2,
    parameter int TRIG_DELAY_IN_20NS_NEG = 35,
    parameter int PULSE_LEN_IN_US        = 1,
    parameter int HOLDOFF_IN_US          = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] trig_in,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [1:0]        mode,
    output logic [NUM_CH-1:0] smoothed_trig,
    output logic              ctrl_out,
    output logic              fire,
    output logic [2:0]        fire_ch,
    output logic              busy,
    output logic [7:0]        missed_cnt
);

    localparam int DELAY_CYC = TRIG_DELAY_IN_US * CLK_MHZ - TRIG_DELAY_IN_20NS_NEG;
    localparam int PULSE_CYC = PULSE_LEN_IN_US * CLK_MHZ;
    localparam int HOLD_CYC  = HOLDOFF_IN_US * CLK_MHZ;
    localparam int MAX_DP    = (DELAY_CYC > PULSE_CYC) ? DELAY_CYC : PULSE_CYC;
    localparam int MAX_CYC   = (MAX_DP > HOLD_CYC) ? MAX_DP : HOLD_CYC;
    localparam int CNT_W     = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

    generate
        if (DELAY_CYC < 1) begin : g_bad_delay
            $error("loctag_trig_sched: derived delay must be at least one cycle");
        end
        if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
            $error("loctag_trig_sched: NUM_CH must be 1..8");
        end
        if (FILT_LEN < 2 || FILT_LEN > 15) begin : g_bad_filt
            $error("loctag_trig_sched: FILT_LEN must be 2..15");
        end
    endgenerate

    // Per-channel conditioning
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            loctag_trig_filter #(
                .FILT_LEN (FILT_LEN)
            ) u_filter (
                .clk      (clk),
                .reset    (reset),
                .trig_raw (trig_in[gi]),
                .level    (smoothed_trig[gi])
            );
        end
    endgenerate

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         run_mode;
    logic [NUM_CH-1:0]  smooth_prev;
    logic [NUM_CH-1:0]  req;
    logic [2:0]         win_idx;
    logic               multi_req;
    logic               accept;
    logic               count_miss;

    assign req       = smoothed_trig & ~smooth_prev & ch_en;
    assign multi_req = (req & (req - NUM_CH'(1))) != '0;
    assign accept    = (state == IDLE) && (|req) &&
                       ((mode == MODE_GATE) || (mode == MODE_MOD));
    // Any request while busy is dropped; in IDLE only the arbitration losers
    // of an accepted request are dropped. At most one count per cycle.
    assign count_miss = (state != IDLE) ? (|req) : (accept && multi_req);
    assign busy       = (state != IDLE);

    // Lowest requesting index wins
    always_comb begin
        win_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            run_mode    <= MODE_OFF;
            smooth_prev <= '0;
            ctrl_out    <= 1'b0;
            fire        <= 1'b0;
            fire_ch     <= '0;
            missed_cnt  <= '0;
        end else begin
            smooth_prev <= smoothed_trig;
            fire        <= 1'b0;

            if (count_miss && (missed_cnt != 8'hFF)) begin
                missed_cnt <= missed_cnt + 8'd1;
            end

            // The live mode input can only abort; the shape of a running
            // window follows the mode latched at acceptance.
            if ((state != IDLE) && (mode == MODE_OFF)) begin
                state    <= IDLE;
                cnt      <= '0;
                ctrl_out <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt      <= '0;
                        ctrl_out <= (mode == MODE_PASS) ? (|(smoothed_trig & ch_en)) : 1'b0;
                        if (accept) begin
                            state    <= DELAY;
                            fire_ch  <= win_idx;
                            run_mode <= mode;
                        end
                    end
                    DELAY: begin
                        if (cnt == DELAY_LAST) begin
                            state    <= ACTIVE;
                            cnt      <= '0;
                            fire     <= 1'b1;
                            ctrl_out <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ACTIVE: begin
                        if (cnt == PULSE_LAST) begin
                            state    <= HOLD;
                            cnt      <= '0;
                            ctrl_out <= 1'b0;
                        end else begin
                            cnt      <= cnt + 1'b1;
                            ctrl_out <= (run_mode == MODE_MOD) ? ~ctrl_out : 1'b1;
                        end
                    end
                    HOLD: begin
                        if (cnt == HOLD_LAST) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        cnt      <= '0;
                        ctrl_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule : loctag_trig_sched
`default_nettype wire

// File: tb/tb_loctag_trig_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_loctag_trig_sched
//  Description : Self-checking bench for loctag_trig_sched with a
//                timestamp-based reference model of filter and scheduler.
//  Revision    : 1.0  initial multi-channel release
// ============================================================================
module tb_loctag_trig_sched;

    localparam int NCH = 4;
    localparam int F   = 4;
    localparam int D   = 2 * 50 - 35;
    localparam int P   = 1 * 50;
    localparam int H   = 1 * 50;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] trig_in;
    logic [NCH-1:0] ch_en;
    logic [1:0]     mode;
    logic [NCH-1:0] smoothed_trig;
    logic           ctrl_out;
    logic           fire;
    logic [2:0]     fire_ch;
    logic           busy;
    logic [7:0]     missed_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state
    logic [NCH-1:0] m_s1, m_s2, m_lvl, m_lvlp;
    int             m_run [NCH];
    logic           m_busy, m_ctrl, m_fire;
    int             m_acc;
    logic [1:0]     m_mode;
    logic [2:0]     m_ch;
    logic [7:0]     m_missed;

    loctag_trig_sched #(
        .NUM_CH                 (4),
        .CLK_MHZ                (50),
        .FILT_LEN               (4),
        .TRIG_DELAY_IN_US       (2),
        .TRIG_DELAY_IN_20NS_NEG (35),
        .PULSE_LEN_IN_US        (1),
        .HOLDOFF_IN_US          (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .trig_in       (trig_in),
        .ch_en         (ch_en),
        .mode          (mode),
        .smoothed_trig (smoothed_trig),
        .ctrl_out      (ctrl_out),
        .fire          (fire),
        .fire_ch       (fire_ch),
        .busy          (busy),
        .missed_cnt    (missed_cnt)
    );

    always #10 clk = ~clk;

    function automatic void model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvlp = '0;
        for (int c = 0; c < NCH; c++) m_run[c] = 0;
        m_busy = 0; m_ctrl = 0; m_fire = 0; m_acc = 0;
        m_mode = 2'b00; m_ch = 3'd0; m_missed = 8'd0;
    endfunction

    // Outputs after one clock edge; the window is tracked as a timestamp of
    // acceptance, and phases follow from elapsed cycles.
    function automatic void model_step();
        logic [NCH-1:0] req;
        int             k;
        bit             found;
        req    = m_lvl & ~m_lvlp & ch_en;
        cyc    = cyc + 1;
        m_fire = 1'b0;
        if (m_busy) begin
            if (req != 0 && m_missed != 8'd255) m_missed = m_missed + 8'd1;
            if (mode == 2'b00) begin
                m_busy = 1'b0;
                m_ctrl = 1'b0;
            end else begin
                k      = cyc - m_acc;
                m_fire = (k == D);
                if (k >= D && k < D + P)
                    m_ctrl = (m_mode == 2'b01) ? 1'b1 : (((k - D) % 2) == 0);
                else
                    m_ctrl = 1'b0;
                if (k >= D + P + H) m_busy = 1'b0;
            end
        end else begin
            m_ctrl = (mode == 2'b11) ? (|(m_lvl & ch_en)) : 1'b0;
            if ((mode == 2'b01 || mode == 2'b10) && req != 0) begin
                m_busy = 1'b1;
                m_acc  = cyc;
                m_mode = mode;
                found  = 0;
                for (int i = 0; i < NCH; i++) begin
                    if (req[i] && !found) begin
                        m_ch  = 3'(i);
                        found = 1;
                    end
                end
                if ($countones(req) > 1 && m_missed != 8'd255) m_missed = m_missed + 8'd1;
            end
        end
        m_lvlp = m_lvl;
        for (int c = 0; c < NCH; c++) begin
            if (m_s2[c] != m_lvl[c]) begin
                m_run[c] = m_run[c] + 1;
                if (m_run[c] == F) begin
                    m_lvl[c] = m_s2[c];
                    m_run[c] = 0;
                end
            end else begin
                m_run[c] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = trig_in;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; trig_in = '0; ch_en = '0; mode = 2'b00;
        repeat (2) @(negedge clk);
        total++; if (smoothed_trig !== 4'h0) begin bad++; $display("FAIL reset_smoothed got=%h want=0", smoothed_trig); end
        total++; if (ctrl_out !== 1'b0)      begin bad++; $display("FAIL reset_ctrl got=%b want=0", ctrl_out); end
        total++; if (fire !== 1'b0)          begin bad++; $display("FAIL reset_fire got=%b want=0", fire); end
        total++; if (fire_ch !== 3'd0)       begin bad++; $display("FAIL reset_fire_ch got=%0d want=0", fire_ch); end
        total++; if (busy !== 1'b0)          begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (missed_cnt !== 8'd0)    begin bad++; $display("FAIL reset_missed got=%0d want=0", missed_cnt); end
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_gate_single();
        int k, rise = -1, fire_at = -1, ctrl_fall = -1, busy_fall = -1, highs = 0;
        mode = 2'b01; ch_en = 4'hF; trig_in = 4'b0001;
        tick();
        k = cyc;
        for (int i = 1; i < 300; i++) begin
            if (i == 10) trig_in = '0;
            tick();
            total++;
            if ({smoothed_trig, ctrl_out, fire, fire_ch, busy, missed_cnt} !== {m_lvl, m_ctrl, m_fire, m_ch, m_busy, m_missed}) begin
                bad++; $display("FAIL gate_model cyc=%0d got=%h want=%h", cyc,
                    {smoothed_trig, ctrl_out, fire, fire_ch, busy, missed_cnt}, {m_lvl, m_ctrl, m_fire, m_ch, m_busy, m_missed});
            end
            if (rise < 0 && smoothed_trig[0]) rise = cyc;
            if (fire_at < 0 && fire) fire_at = cyc;
            if (ctrl_out) highs++;
            if (fire_at >= 0 && ctrl_fall < 0 && !ctrl_out) ctrl_fall = cyc;
            if (fire_at >= 0 && busy_fall < 0 && !busy) busy_fall = cyc;
        end
        total++; if (rise - k !== F + 1)          begin bad++; $display("FAIL gate_rise_lat got=%0d want=%0d", rise - k, F + 1); end
        total++; if (fire_at - rise !== D + 1)    begin bad++; $display("FAIL gate_fire_lat got=%0d want=%0d", fire_at - rise, D + 1); end
        total++; if (highs !== P)                 begin bad++; $display("FAIL gate_ctrl_len got=%0d want=%0d", highs, P); end
        total++; if (ctrl_fall - fire_at !== P)   begin bad++; $display("FAIL gate_ctrl_fall got=%0d want=%0d", ctrl_fall - fire_at, P); end
        total++; if (busy_fall - fire_at !== P + H) begin bad++; $display("FAIL gate_busy_fall got=%0d want=%0d", busy_fall - fire_at, P + H); end
        total++; if (fire_ch !== 3'd0)            begin bad++; $display("FAIL gate_fire_ch got=%0d want=0", fire_ch); end
    endtask

    task automatic test_glitch();
        bit saw_rise = 0, saw_fire = 0;
        trig_in = 4'b0010;
        for (int i = 0; i < 25; i++) begin
            if (i == 3) trig_in = '0;
            tick();
            if (smoothed_trig[1]) saw_rise = 1;
            if (fire) saw_fire = 1;
        end
        total++; if (saw_rise !== 1'b0)   begin bad++; $display("FAIL glitch_rise got=%b want=0", saw_rise); end
        total++; if (saw_fire !== 1'b0)   begin bad++; $display("FAIL glitch_fire got=%b want=0", saw_fire); end
        total++; if (missed_cnt !== 8'd0) begin bad++; $display("FAIL glitch_missed got=%0d want=0", missed_cnt); end
    endtask

    task automatic test_simultaneous();
        int fire_at = -1, fires = 0;
        trig_in = 4'b1100;
        for (int i = 0; i < 260; i++) begin
            if (i == 8) trig_in = '0;
            if (fire_at >= 0 && cyc == fire_at + P + 10) trig_in = 4'b1000;
            if (fire_at >= 0 && cyc == fire_at + P + 18) trig_in = '0;
            tick();
            total++;
            if ({smoothed_trig, ctrl_out, fire, fire_ch, busy, missed_cnt} !== {m_lvl, m_ctrl, m_fire, m_ch, m_busy, m_missed}) begin
                bad++; $display("FAIL simul_model cyc=%0d got=%h want=%h", cyc,
                    {smoothed_trig, ctrl_out, fire, fire_ch, busy, missed_cnt}, {m_lvl, m_ctrl, m_fire, m_ch, m_busy, m_missed});
            end
            if (fire) begin
                fires++;
                if (fire_at < 0) begin
                    fire_at = cyc;
                    total++; if (fire_ch !== 3'd2)    begin bad++; $display("FAIL simul_fire_ch got=%0d want=2", fire_ch); end
                    total++; if (missed_cnt !== 8'd1) begin bad++; $display("FAIL simul_missed1 got=%0d want=1", missed_cnt); end
                end
            end
        end
        total++; if (fires !== 1)         begin bad++; $display("FAIL simul_fires got=%0d want=1", fires); end
        total++; if (missed_cnt !== 8'd2) begin bad++; $display("FAIL simul_missed2 got=%0d want=2", missed_cnt); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL simul_idle got=%b want=0", busy); end
    endtask

    task automatic test_modulate();
        int fire_at = -1, highs = 0, k;
        mode = 2'b10; trig_in = 4'b0001;
        for (int i = 0; i < 260; i++) begin
            if (i == 8) trig_in = '0;
            tick();
            if (fire_at < 0 && fire) fire_at = cyc;
            if (fire_at >= 0) begin
                k = cyc - fire_at;
                if (k < P + 5) begin
                    total++;
                    if (ctrl_out !== ((k < P) && (k % 2 == 0))) begin
                        bad++; $display("FAIL mod_pattern k=%0d got=%b want=%b", k, ctrl_out, (k < P) && (k % 2 == 0));
                    end
                end
                if (ctrl_out) highs++;
            end
        end
        total++; if (highs !== P / 2) begin bad++; $display("FAIL mod_highs got=%0d want=%0d", highs, P / 2); end
        total++; if (busy !== 1'b0)   begin bad++; $display("FAIL mod_idle got=%b want=0", busy); end
    endtask

    task automatic test_abort();
        int fire_at = -1, fires = 0;
        bit checked = 0;
        mode = 2'b01; trig_in = 4'b0001;
        for (int i = 0; i < 200; i++) begin
            if (i == 8) trig_in = '0;
            if (fire_at >= 0 && cyc == fire_at + 10) mode = 2'b00;
            tick();
            if (fire) begin fires++; if (fire_at < 0) fire_at = cyc; end
            if (fire_at >= 0 && cyc == fire_at + 11) begin
                checked = 1;
                total++; if (ctrl_out !== 1'b0) begin bad++; $display("FAIL abort_ctrl got=%b want=0", ctrl_out); end
                total++; if (busy !== 1'b0)     begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
            end
        end
        total++; if (checked !== 1'b1 || fires !== 1) begin bad++; $display("FAIL abort_reached got=%0d fires want=1", fires); end
        mode = 2'b01;
    endtask

    task automatic test_pass();
        logic       exp;
        logic [7:0] miss0;
        int         highs = 0;
        mode = 2'b11; ch_en = 4'b0010; miss0 = m_missed;
        for (int i = 0; i < 60; i++) begin
            trig_in[0] = (i >= 2 && i < 20);
            trig_in[1] = (i >= 10 && i < 35);
            exp = |(m_lvl & ch_en);
            tick();
            total++;
            if ({ctrl_out, busy, fire} !== {exp, 1'b0, 1'b0}) begin
                bad++; $display("FAIL pass_ctrl cyc=%0d got=%b%b%b want=%b00", cyc, ctrl_out, busy, fire, exp);
            end
            if (ctrl_out) highs++;
        end
        total++; if (highs !== 25)          begin bad++; $display("FAIL pass_highs got=%0d want=25", highs); end
        total++; if (missed_cnt !== miss0)  begin bad++; $display("FAIL pass_missed got=%0d want=%0d", missed_cnt, miss0); end
        mode = 2'b01; ch_en = 4'hF; trig_in = '0;
        repeat (10) tick();
    endtask

    task automatic test_saturate();
        logic [7:0] last;
        last = missed_cnt;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < NCH; c++) trig_in[c] = (((i + 2 * c) % 10) < 5);
            tick();
            total++;
            if ({smoothed_trig, ctrl_out, fire, fire_ch, busy, missed_cnt} !== {m_lvl, m_ctrl, m_fire, m_ch, m_busy, m_missed}) begin
                bad++; $display("FAIL sat_model cyc=%0d got=%h want=%h", cyc,
                    {smoothed_trig, ctrl_out, fire, fire_ch, busy, missed_cnt}, {m_lvl, m_ctrl, m_fire, m_ch, m_busy, m_missed});
            end
            if (missed_cnt < last) begin
                total++; bad++; $display("FAIL sat_monotonic got=%0d want>=%0d", missed_cnt, last);
            end
            last = missed_cnt;
        end
        total++; if (missed_cnt !== 8'd255) begin bad++; $display("FAIL sat_value got=%0d want=255", missed_cnt); end
        trig_in = '0;
        repeat (200) tick();
    endtask

    task automatic test_reset_mid();
        int  k, rise = -1, fire_at = -1;
        bit  hit = 0;
        mode = 2'b01; ch_en = 4'hF; trig_in = 4'b0001;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (i == 8) trig_in = '0;
            tick();
            if (rise < 0 && smoothed_trig[0]) rise = cyc;
            if (rise >= 0 && cyc == rise + 20) hit = 1;
        end
        total++; if (!hit || busy !== 1'b1) begin bad++; $display("FAIL rmid_in_delay got busy=%b want=1", busy); end
        #3 reset = 1'b0;
        #1;
        total++;
        if ({smoothed_trig, ctrl_out, fire, fire_ch, busy, missed_cnt} !== 18'd0) begin
            bad++; $display("FAIL rmid_outputs got=%h want=0", {smoothed_trig, ctrl_out, fire, fire_ch, busy, missed_cnt});
        end
        trig_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (5) tick();
        rise = -1;
        trig_in = 4'b0001;
        tick();
        k = cyc;
        for (int i = 1; i < 120; i++) begin
            if (i == 8) trig_in = '0;
            tick();
            if (rise < 0 && smoothed_trig[0]) rise = cyc;
            if (fire_at < 0 && fire) fire_at = cyc;
        end
        total++; if (rise - k !== F + 1)       begin bad++; $display("FAIL rmid_rise got=%0d want=%0d", rise - k, F + 1); end
        total++; if (fire_at - rise !== D + 1) begin bad++; $display("FAIL rmid_fire got=%0d want=%0d", fire_at - rise, D + 1); end
        repeat (120) tick();
    endtask

    task automatic test_random();
        int hold [NCH];
        for (int c = 0; c < NCH; c++) hold[c] = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                mode  = 2'($urandom_range(0, 3));
                ch_en = 4'($urandom);
            end
            for (int c = 0; c < NCH; c++) begin
                hold[c] = hold[c] - 1;
                if (hold[c] <= 0) begin
                    trig_in[c] = ~trig_in[c];
                    hold[c]    = $urandom_range(2, 12);
                end
            end
            tick();
            total++;
            if ({smoothed_trig, ctrl_out, fire, fire_ch, busy, missed_cnt} !== {m_lvl, m_ctrl, m_fire, m_ch, m_busy, m_missed}) begin
                bad++; $display("FAIL rand_model cyc=%0d got=%h want=%h", cyc,
                    {smoothed_trig, ctrl_out, fire, fire_ch, busy, missed_cnt}, {m_lvl, m_ctrl, m_fire, m_ch, m_busy, m_missed});
            end
        end
    endtask

    initial begin
        reset = 1'b0; trig_in = '0; ch_en = '0; mode = 2'b00;
        model_reset();
        test_reset();
        test_gate_single();
        test_glitch();
        test_simultaneous();
        test_modulate();
        test_abort();
        test_pass();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_loctag_trig_sched
`default_nettype wire
